// File: rtl/tt_um_input_debounce_pkg.sv
// Shared constants for the input debounce stage: pin-direction mask, event
// counter geometry and the default debounce length.
package tt_um_input_debounce_pkg;

    localparam logic [7:0]  IO_OE_MASK              = 8'hF0;
    localparam int unsigned EVT_CNT_W               = 4;
    localparam int unsigned SEL_W                   = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only flips the stable level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            // Any sample agreeing with the stable level restarts the count.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/tt_um_input_debounce.sv
// Debounces all ui_in bits onto uo_out and counts rising edges of one
// selectable debounced bit, shown on uio_out[7:4] for bring-up.
module tt_um_input_debounce
    import tt_um_input_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0]     stable;
    logic [SEL_W-1:0]     sel;
    logic                 clear;
    logic                 sel_bit;
    logic                 sel_bit_q;
    logic                 rise;
    logic [EVT_CNT_W-1:0] count_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (ui_in[i]),
            .dout (stable[i])
        );
    end

    // sel is quasi-static; switching it may produce one spurious rise.
    assign sel     = uio_in[SEL_W-1:0];
    assign clear   = uio_in[2];
    assign sel_bit = stable[sel];
    assign rise    = sel_bit & ~sel_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_bit_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sel_bit_q <= sel_bit;
            if (clear) begin
                count_q <= '0;
            end else if (rise) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign uo_out  = stable;
    assign uio_out = {count_q, 4'b0000};
    assign uio_oe  = IO_OE_MASK;

    logic unused_pins;
    assign unused_pins = ^{ena, uio_in[7:3]};

endmodule
